// File: rtl/uart_reg_pkg.sv
// Shared command/response byte codes and FSM state type for the UART register bridge.
package uart_reg_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_RESP,
    ST_RESP_GAP
  } state_e;

endpackage

// File: rtl/uart_reg_timeout.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled, flags the
// cycle on which the count would reach TIMEOUT_CYC-1.
module uart_reg_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire is independent of clr_i so a coincident byte cannot mask the timeout.
  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes 'W' addr data / 'R' addr frames from the UART byte stream into register bus
// strobes and returns one response byte per frame through the UART write port.
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_wr_en,
  output logic [7:0] tx_wr_data,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       frame_timeout,
  output logic       rx_drop
);

  import uart_reg_pkg::*;

  state_e     state_q, state_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, tx_data_q, tx_data_d;
  logic       reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, tx_en_q, tx_en_d;
  logic       tmo_q, tmo_d, drop_q, drop_d;
  logic       tmo_clr, tmo_en, tmo_expire;

  uart_reg_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    reg_wr_d  = 1'b0;
    reg_rd_d  = 1'b0;
    tx_en_d   = 1'b0;
    tmo_d     = 1'b0;
    drop_d    = 1'b0;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            is_rd_d = (rx_data == CMD_RD);
            tmo_clr = 1'b1;
            state_d = ST_GET_ADDR;
          end else begin
            tx_data_d = RSP_ERR;
            state_d   = ST_RESP;
          end
        end
      end
      ST_GET_ADDR, ST_GET_DATA: begin
        tmo_en = 1'b1;
        if (tmo_expire) begin
          tmo_d   = 1'b1;
          drop_d  = rx_valid;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          tmo_clr = 1'b1;
          if (state_q == ST_GET_ADDR) begin
            addr_d = rx_data;
            if (is_rd_q) begin
              reg_rd_d = 1'b1;
              state_d  = ST_RD_ISSUE;
            end else begin
              state_d  = ST_GET_DATA;
            end
          end else begin
            wdata_d   = rx_data;
            reg_wr_d  = 1'b1;
            tx_data_d = RSP_OK;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RD_ISSUE: begin
        drop_d  = rx_valid;
        state_d = ST_RD_CAP;
      end
      // Capture and launch share this cycle so the response leaves at c+3 after the addr byte.
      ST_RD_CAP, ST_RESP: begin
        drop_d = rx_valid;
        if (state_q == ST_RD_CAP) begin
          tx_data_d = reg_rdata;
        end
        if (!tx_busy) begin
          tx_en_d = 1'b1;
          state_d = ST_RESP_GAP;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP_GAP: begin
        drop_d  = rx_valid;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      tx_en_q   <= 1'b0;
      tmo_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      tx_en_q   <= tx_en_d;
      tmo_q     <= tmo_d;
      drop_q    <= drop_d;
    end
  end

  assign tx_wr_en      = tx_en_q;
  assign tx_wr_data    = tx_data_q;
  assign reg_wr        = reg_wr_q;
  assign reg_rd        = reg_rd_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;
  assign frame_timeout = tmo_q;
  assign rx_drop       = drop_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a small register-file model on the bus.
`timescale 1ns/1ps
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       frame_timeout;
  logic       rx_drop;

  int vectors = 0;
  int miscompares = 0;
  int cnt_wr = 0, cnt_rd = 0, cnt_tx = 0, cnt_to = 0, cnt_drop = 0;
  int b_wr, b_rd, b_tx, b_to, b_drop;

  logic [7:0] mem [256];

  uart_reg_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .tx_wr_en      (tx_wr_en),
    .tx_wr_data    (tx_wr_data),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .frame_timeout (frame_timeout),
    .rx_drop       (rx_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr) mem[reg_addr] <= reg_wdata;
    if (reg_rd) reg_rdata <= mem[reg_addr];
    if (reg_wr) cnt_wr <= cnt_wr + 1;
    if (reg_rd) cnt_rd <= cnt_rd + 1;
    if (tx_wr_en) cnt_tx <= cnt_tx + 1;
    if (frame_timeout) cnt_to <= cnt_to + 1;
    if (rx_drop) cnt_drop <= cnt_drop + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic snap();
    b_wr = cnt_wr; b_rd = cnt_rd; b_tx = cnt_tx; b_to = cnt_to; b_drop = cnt_drop;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    step(); step();
    chk("reset_outputs", {tx_wr_en, reg_wr, reg_rd, frame_timeout, rx_drop,
                          tx_wr_data, reg_addr, reg_wdata}, 32'h0);
    rst = 1'b0;
    step();

    // write 0x10 <- 0xA5
    snap();
    send(8'h57); send(8'h10);
    chk("wr_addr", reg_addr, 8'h10);
    send(8'hA5);
    chk("wr_strobe", reg_wr, 1'b1);
    chk("wr_wdata", reg_wdata, 8'hA5);
    chk("wr_resp_byte", tx_wr_data, 8'h4B);
    chk("wr_en_early", tx_wr_en, 1'b0);
    step();
    chk("wr_tx_en", tx_wr_en, 1'b1);
    chk("wr_strobe_single", reg_wr, 1'b0);
    step();
    chk("wr_tx_en_single", tx_wr_en, 1'b0);
    step(); step();
    chk("wr_cnt_wr", cnt_wr - b_wr, 1);
    chk("wr_cnt_rd", cnt_rd - b_rd, 0);
    chk("wr_cnt_tx", cnt_tx - b_tx, 1);

    // rewrite 0x10 <- 0x3C, then read it back
    send(8'h57); send(8'h10); send(8'h3C);
    step(); step(); step();
    snap();
    send(8'h52); send(8'h10);
    chk("rd_strobe", reg_rd, 1'b1);
    chk("rd_addr", reg_addr, 8'h10);
    step();
    chk("rd_en_c2", tx_wr_en, 1'b0);
    step();
    chk("rd_en_c3", tx_wr_en, 1'b1);
    chk("rd_resp_byte", tx_wr_data, 8'h3C);
    step(); step();
    chk("rd_cnt_rd", cnt_rd - b_rd, 1);
    chk("rd_cnt_wr", cnt_wr - b_wr, 0);
    chk("rd_cnt_tx", cnt_tx - b_tx, 1);

    // unknown command byte
    snap();
    send(8'h00);
    chk("err_resp_byte", tx_wr_data, 8'h45);
    step();
    chk("err_tx_en", tx_wr_en, 1'b1);
    step(); step();
    chk("err_no_bus", (cnt_wr - b_wr) + (cnt_rd - b_rd), 0);
    chk("err_cnt_tx", cnt_tx - b_tx, 1);

    // timeout after a partial write frame
    send(8'h57); send(8'h20); send(8'h5A);
    step(); step(); step();
    snap();
    send(8'h57); send(8'h20);
    repeat (14) step();
    chk("to_early", frame_timeout, 1'b0);
    step();
    chk("to_pulse", frame_timeout, 1'b1);
    step();
    chk("to_single", frame_timeout, 1'b0);
    repeat (3) step();
    chk("to_no_activity", (cnt_wr - b_wr) + (cnt_rd - b_rd) + (cnt_tx - b_tx), 0);
    chk("to_cnt", cnt_to - b_to, 1);
    send(8'h52); send(8'h20);
    step(); step();
    chk("to_next_rd_en", tx_wr_en, 1'b1);
    chk("to_next_rd_byte", tx_wr_data, 8'h5A);
    step(); step();

    // response held off by tx_busy, stray byte dropped
    send(8'h57); send(8'h30);
    tx_busy = 1'b1;
    send(8'h11);
    snap();
    repeat (10) step();
    send(8'h57);
    chk("busy_drop_pulse", rx_drop, 1'b1);
    repeat (38) step();
    chk("busy_hold", cnt_tx - b_tx, 0);
    tx_busy = 1'b0;
    step();
    chk("busy_release_en", tx_wr_en, 1'b1);
    chk("busy_release_byte", tx_wr_data, 8'h4B);
    step(); step();
    chk("busy_cnt_drop", cnt_drop - b_drop, 1);
    chk("busy_cnt_tx", cnt_tx - b_tx, 1);
    send(8'h00);
    step();
    chk("busy_idle_after", {tx_wr_en, tx_wr_data}, {1'b1, 8'h45});
    step(); step();

    // asynchronous reset in GET_DATA
    send(8'h57); send(8'h40);
    chk("rst_pre_addr", reg_addr, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {tx_wr_en, reg_wr, reg_rd, frame_timeout, rx_drop,
                            tx_wr_data, reg_addr, reg_wdata}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    send(8'h57); send(8'h40); send(8'h77);
    chk("rst_after_wr", {reg_wr, reg_addr, reg_wdata}, {1'b1, 8'h40, 8'h77});
    step();
    chk("rst_after_resp", {tx_wr_en, tx_wr_data}, {1'b1, 8'h4B});
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-stream command decoder sitting directly downstream of `uart_top`'s receiver and upstream of its transmitter. Consumes received bytes (`rx_valid`/`rx_data`), decodes single-byte-address write and read frames, drives an 8-bit synchronous register bus, and returns one response byte per frame through the UART write port (`wr_en`/`wr_data`, gated by `tx_busy`).

## Interface
- `TIMEOUT_CYC`, 100000, inter-byte timeout in clk cycles while a frame is partially received (≥2).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; the top level drives `rst = ~rstb`.
- `rx_valid`  in  1  one-cycle pulse from UART receiver.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_wr_en`  out  1  one-cycle pulse to UART `wr_en`.
- `tx_wr_data`  out  8  response byte to UART `wr_data`.
- `reg_wr`  out  1  register write strobe, one cycle.
- `reg_rd`  out  1  register read strobe, one cycle.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  register write data.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_rd`.
- `frame_timeout`  out  1  one-cycle pulse on timeout abort.
- `rx_drop`  out  1  one-cycle pulse when a byte arrives outside a receive state.

## Operation
- Frames: write = 0x57 ('W'), addr, data → response 0x4B ('K'). Read = 0x52 ('R'), addr → response = register data. Any other first byte → response 0x45 ('E'), no bus access.
- States: IDLE, GET_ADDR, GET_DATA, RD_ISSUE, RD_CAP, RESP, RESP_GAP.
- IDLE: on `rx_valid`, 'W'/'R' → GET_ADDR (latch command); other → RESP with `tx_wr_data`=0x45.
- GET_ADDR: on `rx_valid` latch `reg_addr`; 'W' → GET_DATA; 'R' → RD_ISSUE.
- GET_DATA: on `rx_valid` latch `reg_wdata`, assert `reg_wr` next cycle, load 0x4B → RESP.
- RD_ISSUE: `reg_rd`=1 for this cycle → RD_CAP.
- RD_CAP: capture `reg_rdata` into `tx_wr_data` → RESP.
- RESP: when `tx_busy`=0, `tx_wr_en`=1 for exactly one cycle → RESP_GAP. Stays in RESP while `tx_busy`=1.
- RESP_GAP: one cycle (UART raises `tx_busy` the cycle after `wr_en`; `tx_busy` is ignored here) → IDLE.
- Timeout: counter cleared on entry to GET_ADDR and on every accepted byte; increments in GET_ADDR/GET_DATA; reaching TIMEOUT_CYC-1 → IDLE, `frame_timeout` pulse, no response, no bus access.
- `rx_valid` in RD_ISSUE, RD_CAP, RESP, RESP_GAP: byte discarded, `rx_drop` pulses; FSM unaffected.
- `rx_valid` coincident with the timeout cycle: timeout wins, byte discarded, `rx_drop` pulses.
- `rst` mid-frame or mid-response: immediate return to IDLE; no pending strobe survives.

## Timing
- All outputs registered. Reset values: all strobes 0, `tx_wr_data`/`reg_addr`/`reg_wdata` = 0x00, state IDLE, counter 0.
- Write: data-byte `rx_valid` in cycle c → `reg_wr` in c+1 → `tx_wr_en` in c+2 if `tx_busy`=0 in c+1.
- Read: addr-byte `rx_valid` in c → `reg_rd` in c+1 → `reg_rdata` sampled at end of c+2 → `tx_wr_en` in c+3 at earliest.
- Error: bad byte in c → `tx_wr_en` in c+2 at earliest.
- `reg_addr`/`reg_wdata` hold stable from the latch until the next frame's latch.
- Never two `tx_wr_en` pulses closer than 2 cycles; never `reg_wr` and `reg_rd` together.

## Structure
- Package `uart_reg_pkg`: command constants (0x57, 0x52), response constants (0x4B, 0x45), state enum typedef.
- One sub-module natural: `uart_reg_timeout` (clear/enable/expire counter, width `$clog2(TIMEOUT_CYC)`).

## Test plan
- Write frame 0x57,0x10,0xA5 → one `reg_wr` with addr 0x10, wdata 0xA5; `tx_wr_data`=0x4B with one `tx_wr_en`.
- Read frame 0x52,0x10, model returns 0x3C → one `reg_rd` addr 0x10; response byte 0x3C, `tx_wr_en` exactly 3 cycles after addr `rx_valid` with `tx_busy`=0.
- Byte 0x00 in IDLE → response 0x45, no `reg_wr`/`reg_rd`.
- 0x57,0x20 then silence (TIMEOUT_CYC=16) → `frame_timeout` at 15 cycles after last byte; no strobes, no response; next frame 0x52,0x20 decodes normally.
- Hold `tx_busy`=1 for 50 cycles during RESP, inject `rx_valid` 0x57 → `tx_wr_en` only after `tx_busy` falls; `rx_drop` pulses once; IDLE afterwards.
- Assert `rst` in GET_DATA → all outputs at reset values; next full write frame completes correctly. Full loopback with `uart_top` and random frames against a scoreboard.
